ct_ifu_btb_upd_arb: RTL and testbench

Single write-port arbiter and sequencer for the IFU main BTB.
- Merges speculative misprediction updates from the IB-stage address generator with resolved-branch updates from the BJU.
- Runs a full-array invalidate sweep on CP0 request.
- Write slots are taken only when the ifctrl read port leaves the array free, so the BTB keeps a single write port.

---
 rtl/ct_ifu_btb_upd_arb.sv | 255 +++++++++++++++++++++++++
 tb/tb_ct_ifu_btb_upd_arb.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_ifu_btb_upd_arb.sv
// ---------------------------------------------------------------------------
// ct_ifu_btb_upd_arb
//
// Purpose:
//   Owns the single write port of the IFU main BTB. This block does three jobs:
//   - It merges speculative mispredict updates from the IB-stage address
//     generator (requester A) with resolved-branch updates from the BJU
//     (requester B).
//   - It runs a full-array invalidate sweep when CP0 requests one.
//   - It issues a write only in cycles where the ifctrl read port leaves the
//     array free.
//
// Optional build macro:
//   CT_IFU_BTB_UPD_CNT_EN - adds upd_drop_cnt, a 16-bit saturating count of
//                           upd_drop pulses. The count is cleared by reset and
//                           by entry to the sweep.
//
// Ports:
//   forever_cpuclk              clock
//   cpurst_b                    synchronous active-low reset
//   addrgen_upd_vld/index/tag/target   requester A update pulse and payload
//   bju_upd_vld/index/tag/target       requester B update pulse and payload
//   cp0_btb_inv                 invalidate-all request pulse
//   ifctrl_btb_rd               array is being read this cycle (no write)
//   btb_wen/windex/wtag/wtarget/wvld   BTB write port
//   btb_inv_busy                sweep in progress (INV or DONE)
//   btb_inv_done                one-cycle pulse when the sweep completes
//   upd_drop                    one-cycle pulse: at least one update was lost
//   upd_drop_cnt                (optional) saturating count of upd_drop pulses
// ---------------------------------------------------------------------------
module ct_ifu_btb_upd_arb #(
  parameter int INDEX_W   = 10,
  parameter int TAG_W     = 10,
  parameter int TGT_W     = 20,
  parameter int INV_DEPTH = 1024
) (
  input  logic               forever_cpuclk,
  input  logic               cpurst_b,
  input  logic               addrgen_upd_vld,
  input  logic [INDEX_W-1:0] addrgen_upd_index,
  input  logic [TAG_W-1:0]   addrgen_upd_tag,
  input  logic [TGT_W-1:0]   addrgen_upd_target,
  input  logic               bju_upd_vld,
  input  logic [INDEX_W-1:0] bju_upd_index,
  input  logic [TAG_W-1:0]   bju_upd_tag,
  input  logic [TGT_W-1:0]   bju_upd_target,
  input  logic               cp0_btb_inv,
  input  logic               ifctrl_btb_rd,
  output logic               btb_wen,
  output logic [INDEX_W-1:0] btb_windex,
  output logic [TAG_W-1:0]   btb_wtag,
  output logic [TGT_W-1:0]   btb_wtarget,
  output logic               btb_wvld,
  output logic               btb_inv_busy,
  output logic               btb_inv_done,
  output logic               upd_drop
`ifdef CT_IFU_BTB_UPD_CNT_EN
  ,
  output logic [15:0]        upd_drop_cnt
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INV  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [INDEX_W-1:0] INV_LAST = INDEX_W'(INV_DEPTH - 1);

  // FSM and sweep counter
  logic [1:0]         state_reg, state_next;
  logic [INDEX_W-1:0] inv_cnt_reg, inv_cnt_next;

  // Pending entry A (addrgen)
  logic               a_vld_reg, a_vld_next;
  logic [INDEX_W-1:0] a_index_reg, a_index_next;
  logic [TAG_W-1:0]   a_tag_reg, a_tag_next;
  logic [TGT_W-1:0]   a_target_reg, a_target_next;

  // Pending entry B (BJU)
  logic               b_vld_reg, b_vld_next;
  logic [INDEX_W-1:0] b_index_reg, b_index_next;
  logic [TAG_W-1:0]   b_tag_reg, b_tag_next;
  logic [TGT_W-1:0]   b_target_reg, b_target_next;

  logic st_idle, st_inv, st_done;
  logic grant_a, grant_b, stale_a, inv_wr;
  logic a_keep, b_keep, enter_inv;
  logic drop_raw;

  assign st_idle = (state_reg == ST_IDLE);
  assign st_inv  = (state_reg == ST_INV);
  assign st_done = (state_reg == ST_DONE);

  // B (resolved) outranks A (speculative); a read blocks every write.
  assign grant_b = st_idle & ~ifctrl_btb_rd & b_vld_reg;
  assign grant_a = st_idle & ~ifctrl_btb_rd & a_vld_reg & ~b_vld_reg;

  // A targets the same entry B is writing now, so A's prediction is older
  // than the resolved outcome and must not overwrite it later.
  assign stale_a = grant_b & a_vld_reg & (a_index_reg == b_index_reg);

  assign inv_wr    = st_inv & ~ifctrl_btb_rd;
  assign enter_inv = st_idle & cp0_btb_inv;

  // Entries that survive this cycle without being written or discarded.
  assign a_keep = a_vld_reg & ~grant_a & ~stale_a;
  assign b_keep = b_vld_reg & ~grant_b;

  // -------------------------------------------------------------------------
  // Pending-entry update and drop detection
  // -------------------------------------------------------------------------
  always_comb begin
    a_vld_next    = a_keep;
    a_index_next  = a_index_reg;
    a_tag_next    = a_tag_reg;
    a_target_next = a_target_reg;
    b_vld_next    = b_keep;
    b_index_next  = b_index_reg;
    b_tag_next    = b_tag_reg;
    b_target_next = b_target_reg;
    drop_raw      = 1'b0;

    if (st_idle) begin
      if (addrgen_upd_vld) begin
        a_vld_next    = 1'b1;
        a_index_next  = addrgen_upd_index;
        a_tag_next    = addrgen_upd_tag;
        a_target_next = addrgen_upd_target;
      end
      if (bju_upd_vld) begin
        b_vld_next    = 1'b1;
        b_index_next  = bju_upd_index;
        b_tag_next    = bju_upd_tag;
        b_target_next = bju_upd_target;
      end
      // A request replacing an entry that is still waiting loses the old one.
      // Several simultaneous losses still produce a single pulse.
      drop_raw = stale_a | (addrgen_upd_vld & a_keep) | (bju_upd_vld & b_keep);
      // Starting a sweep throws away everything that would still be pending,
      // including requests captured in this same cycle.
      if (enter_inv) begin
        drop_raw   = drop_raw | a_vld_next | b_vld_next;
        a_vld_next = 1'b0;
        b_vld_next = 1'b0;
      end
    end else begin
      // Requests are not captured while the sweep owns the array.
      drop_raw = addrgen_upd_vld | bju_upd_vld;
    end
  end

  // -------------------------------------------------------------------------
  // FSM and sweep counter
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    inv_cnt_next = inv_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cp0_btb_inv) begin
          state_next = ST_INV;
        end
      end
      ST_INV: begin
        if (inv_wr) begin
          // The counter wraps back to 0 naturally after the last index.
          inv_cnt_next = inv_cnt_reg + 1'b1;
          if (inv_cnt_reg == INV_LAST) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state_reg   <= ST_IDLE;
      inv_cnt_reg <= '0;
      a_vld_reg   <= 1'b0;
      b_vld_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      inv_cnt_reg <= inv_cnt_next;
      a_vld_reg   <= a_vld_next;
      b_vld_reg   <= b_vld_next;
    end
  end

  // Payload registers are qualified by the valid bits and need no reset.
  always_ff @(posedge forever_cpuclk) begin
    a_index_reg  <= a_index_next;
    a_tag_reg    <= a_tag_next;
    a_target_reg <= a_target_next;
    b_index_reg  <= b_index_next;
    b_tag_reg    <= b_tag_next;
    b_target_reg <= b_target_next;
  end

  // -------------------------------------------------------------------------
  // Write port and status outputs. These are forced low while reset is held.
  // -------------------------------------------------------------------------
  always_comb begin
    btb_wen     = 1'b0;
    btb_windex  = '0;
    btb_wtag    = '0;
    btb_wtarget = '0;
    btb_wvld    = 1'b0;
    if (cpurst_b) begin
      if (grant_b) begin
        btb_wen     = 1'b1;
        btb_windex  = b_index_reg;
        btb_wtag    = b_tag_reg;
        btb_wtarget = b_target_reg;
        btb_wvld    = 1'b1;
      end else if (grant_a) begin
        btb_wen     = 1'b1;
        btb_windex  = a_index_reg;
        btb_wtag    = a_tag_reg;
        btb_wtarget = a_target_reg;
        btb_wvld    = 1'b1;
      end else if (inv_wr) begin
        btb_wen     = 1'b1;
        btb_windex  = inv_cnt_reg;
      end
    end
  end

  assign btb_inv_busy = cpurst_b & (st_inv | st_done);
  assign btb_inv_done = cpurst_b & st_done;
  assign upd_drop     = cpurst_b & drop_raw;

`ifdef CT_IFU_BTB_UPD_CNT_EN
  logic [15:0] drop_cnt_reg;

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      drop_cnt_reg <= '0;
    end else if (enter_inv) begin
      drop_cnt_reg <= '0;
    end else if (drop_raw && (drop_cnt_reg != 16'hFFFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end

  assign upd_drop_cnt = cpurst_b ? drop_cnt_reg : 16'd0;
`endif

endmodule

// File: tb/tb_ct_ifu_btb_upd_arb.sv
// ---------------------------------------------------------------------------
// tb_ct_ifu_btb_upd_arb
//
// Purpose:
//   Checks ct_ifu_btb_upd_arb against a behavioural model of the update
//   arbitration and the invalidate sweep. Directed scenarios are followed by
//   randomized traffic. The model describes the sweep by "next index to
//   clear". It describes each requester as an entry that is either empty or
//   waiting.
// ---------------------------------------------------------------------------
module tb_ct_ifu_btb_upd_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_v, b_v, cp0, rd;
  logic [9:0]  a_i, a_t, b_i, b_t;
  logic [19:0] a_g, b_g;

  logic        wen, wvld, busy, done, drop;
  logic [9:0]  windex, wtag;
  logic [19:0] wtarget;
`ifdef CT_IFU_BTB_UPD_CNT_EN
  logic [15:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  ct_ifu_btb_upd_arb dut (
    .forever_cpuclk     (clk),
    .cpurst_b           (rst_n),
    .addrgen_upd_vld    (a_v),
    .addrgen_upd_index  (a_i),
    .addrgen_upd_tag    (a_t),
    .addrgen_upd_target (a_g),
    .bju_upd_vld        (b_v),
    .bju_upd_index      (b_i),
    .bju_upd_tag        (b_t),
    .bju_upd_target     (b_g),
    .cp0_btb_inv        (cp0),
    .ifctrl_btb_rd      (rd),
    .btb_wen            (wen),
    .btb_windex         (windex),
    .btb_wtag           (wtag),
    .btb_wtarget        (wtarget),
    .btb_wvld           (wvld),
    .btb_inv_busy       (busy),
    .btb_inv_done       (done),
    .upd_drop           (drop)
`ifdef CT_IFU_BTB_UPD_CNT_EN
    ,
    .upd_drop_cnt       (drop_cnt)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit          v;
    logic [9:0]  idx;
    logic [9:0]  tag;
    logic [19:0] tgt;
  } ent_t;

  ent_t m_a, m_b;
  bit   m_sweep, m_fin;
  int   m_pos;     // next index the sweep will clear
  int   m_cnt;     // saturating drop count

  int n_tests = 0;
  int n_fail  = 0;
  int inv_writes, done_pulses, drop_pulses;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle. Inputs must already be set. The model evaluates the
  // cycle at the falling edge, while inputs are stable, and the DUT outputs
  // are compared there. Pulse inputs are cleared after the rising edge.
  task automatic tick();
    bit          e_wen, e_wvld, e_busy, e_done, e_drop, enter;
    logic [9:0]  e_idx, e_tag;
    logic [19:0] e_tgt;
    @(negedge clk);
    e_wen = 0; e_wvld = 0; e_busy = 0; e_done = 0; e_drop = 0; enter = 0;
    e_idx = '0; e_tag = '0; e_tgt = '0;
`ifdef CT_IFU_BTB_UPD_CNT_EN
    chk("drop_cnt", drop_cnt, rst_n ? m_cnt : 0);
`endif
    if (!rst_n) begin
      m_a.v = 0; m_b.v = 0; m_sweep = 0; m_fin = 0; m_pos = 0; m_cnt = 0;
    end else if (m_sweep) begin
      e_busy = 1;
      e_drop = a_v | b_v;
      if (!rd) begin
        e_wen = 1; e_idx = 10'(m_pos);
        m_pos++;
        if (m_pos == 1024) begin m_sweep = 0; m_fin = 1; m_pos = 0; end
      end
    end else if (m_fin) begin
      e_busy = 1; e_done = 1; e_drop = a_v | b_v; m_fin = 0;
    end else begin
      if (!rd && m_b.v) begin
        e_wen = 1; e_wvld = 1; e_idx = m_b.idx; e_tag = m_b.tag; e_tgt = m_b.tgt;
        m_b.v = 0;
        if (m_a.v && m_a.idx == m_b.idx) begin m_a.v = 0; e_drop = 1; end
      end else if (!rd && m_a.v) begin
        e_wen = 1; e_wvld = 1; e_idx = m_a.idx; e_tag = m_a.tag; e_tgt = m_a.tgt;
        m_a.v = 0;
      end
      if (a_v) begin
        if (m_a.v) e_drop = 1;
        m_a.v = 1; m_a.idx = a_i; m_a.tag = a_t; m_a.tgt = a_g;
      end
      if (b_v) begin
        if (m_b.v) e_drop = 1;
        m_b.v = 1; m_b.idx = b_i; m_b.tag = b_t; m_b.tgt = b_g;
      end
      if (cp0) begin
        if (m_a.v || m_b.v) e_drop = 1;
        m_a.v = 0; m_b.v = 0; m_sweep = 1; m_pos = 0; enter = 1;
      end
    end
    if (rst_n) begin
      if (enter) m_cnt = 0;
      else if (e_drop && m_cnt < 16'hFFFF) m_cnt++;
    end

    chk("wen", wen, e_wen);
    if (e_wen) begin
      chk("windex", windex, e_idx);
      chk("wtag", wtag, e_tag);
      chk("wtarget", wtarget, e_tgt);
      chk("wvld", wvld, e_wvld);
    end
    chk("inv_busy", busy, e_busy);
    chk("inv_done", done, e_done);
    chk("upd_drop", drop, e_drop);
    if (wen && !wvld) inv_writes++;
    if (done) done_pulses++;
    if (drop) drop_pulses++;

    @(posedge clk);
    #1;
    a_v = 0; b_v = 0; cp0 = 0;
  endtask

  task automatic req_a(input logic [9:0] i, input logic [9:0] t, input logic [19:0] g);
    a_v = 1; a_i = i; a_t = t; a_g = g;
  endtask

  task automatic req_b(input logic [9:0] i, input logic [9:0] t, input logic [19:0] g);
    b_v = 1; b_i = i; b_t = t; b_g = g;
  endtask

  initial begin
    int guard;
    rst_n = 0; a_v = 0; b_v = 0; cp0 = 0; rd = 0;
    a_i = '0; a_t = '0; a_g = '0; b_i = '0; b_t = '0; b_g = '0;
    m_a = '{0, '0, '0, '0}; m_b = '{0, '0, '0, '0};
    m_sweep = 0; m_fin = 0; m_pos = 0; m_cnt = 0;
    inv_writes = 0; done_pulses = 0; drop_pulses = 0;
    @(posedge clk); #1;

    // Reset: outputs stay low, even with requests asserted.
    $display("[TB] scenario: reset");
    tick();
    req_a(10'h3, 10'h3, 20'h3); cp0 = 1;
    tick();
    tick();
    rst_n = 1;

    // Single update, one cycle of latency.
    $display("[TB] scenario: single update");
    req_a(10'h155, 10'h2AA, 20'h12345);
    tick(); tick(); tick();

    // Same-index conflict: B wins and A is discarded.
    $display("[TB] scenario: same-index priority");
    req_a(10'h010, 10'h011, 20'h0AAAA); req_b(10'h010, 10'h022, 20'h0BBBB);
    tick(); tick(); tick(); tick();

    // Different indices, blocked by reads for three cycles.
    $display("[TB] scenario: read blocking");
    rd = 1;
    req_a(10'h001, 10'h101, 20'h11111); req_b(10'h002, 10'h202, 20'h22222);
    tick(); tick(); tick();
    rd = 0;
    drop_pulses = 0;
    tick(); tick(); tick();
    chk("blk_no_drop", drop_pulses, 0);

    // Overwrite of a waiting entry.
    $display("[TB] scenario: overwrite");
    rd = 1;
    req_a(10'h005, 10'h055, 20'h55555); tick();
    req_a(10'h006, 10'h066, 20'h66666); tick();
    rd = 0;
    tick(); tick();

    // Invalidate sweep with the read port busy every other cycle.
    $display("[TB] scenario: invalidate with stalls");
    inv_writes = 0; done_pulses = 0;
    cp0 = 1; tick();
    guard = 0;
    while ((m_sweep || m_fin) && guard < 5000) begin
      rd = guard[0];
      if (guard == 100) req_b(10'h077, 10'h077, 20'h77777);
      if (guard == 101) cp0 = 1;
      tick();
      guard++;
    end
    chk("inv_timeout", (guard < 5000) ? 1 : 0, 1);
    rd = 0;
    tick(); tick();
    chk("inv_writes", inv_writes, 1024);
    chk("inv_done_pulses", done_pulses, 1);

    // Reset in the middle of a sweep, then restart the sweep.
    $display("[TB] scenario: reset mid-sweep");
    cp0 = 1; tick();
    guard = 0;
    while (m_pos < 300 && guard < 1000) begin tick(); guard++; end
    rst_n = 0; tick();
    rst_n = 1; tick();
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_wen", wen, 0);
    cp0 = 1; tick();
    tick();   // the model expects a write at index 0 here
    rst_n = 0; tick(); rst_n = 1;

    // Randomized traffic.
    $display("[TB] scenario: random traffic");
    for (int c = 0; c < 4000; c++) begin
      rd = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0)
        req_a(10'($urandom_range(0, 3)), 10'($urandom), 20'($urandom));
      if ($urandom_range(0, 2) == 0)
        req_b(10'($urandom_range(0, 3)), 10'($urandom), 20'($urandom));
      cp0 = ($urandom_range(0, 799) == 0);
      rst_n = ($urandom_range(0, 2999) != 0);
      tick();
    end
    rst_n = 1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
